// File: rtl/flit_reader.sv
// flit_reader
//
// Consumer-side front end for a router input buffer. Pops flits from a FIFO
// whose read data arrives one cycle after the pop request. Those in-flight
// flits land in a 3-entry skid queue, and the queue front is presented on a
// valid/ready link. The block also tracks head/body/tail framing, supplies
// the destination of the packet currently being forwarded, silently drops
// orphan flits, and counts completed packets.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   fifo_rd_en    pop request to the FIFO
//   fifo_empty    FIFO empty flag
//   fifo_rd_data  FIFO read data, valid the cycle after fifo_rd_en
//   out_valid     a flit is offered on out_data
//   out_ready     downstream accepts the offered flit
//   out_data      front flit of the skid queue
//   out_dest      destination of the packet owning out_data
//   pkt_err       one-cycle pulse per framing error
//   pkt_count     completed packets (tail or single accepted), wrapping
//
// Flit format: [DATA_WIDTH-1:DATA_WIDTH-2] type (01 head, 00 body, 10 tail,
// 11 single), [ADDR_WIDTH-1:0] destination on head/single flits.

module flit_reader #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  fifo_rd_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_dest,
    output logic                  pkt_err,
    output logic [15:0]           pkt_count
);

    typedef enum logic {
        IDLE,
        IN_PKT
    } state_t;

    localparam logic [1:0] TYPE_BODY   = 2'b00;
    localparam logic [1:0] TYPE_HEAD   = 2'b01;
    localparam logic [1:0] TYPE_TAIL   = 2'b10;
    localparam logic [1:0] TYPE_SINGLE = 2'b11;

    logic [DATA_WIDTH-1:0] queue_mem [0:2];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [1:0]            occ;
    logic                  inflight;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] dest_reg;
    logic [ADDR_WIDTH-1:0] dest_next;
    logic                  err_next;
    logic                  count_inc;
    logic                  orphan_pop;

    logic                  has_front;
    logic [DATA_WIDTH-1:0] front;
    logic [1:0]            front_type;
    logic                  accept;
    logic                  push;
    logic                  pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign has_front  = (occ != 2'd0);
    assign front      = queue_mem[rd_ptr];
    assign front_type = front[DATA_WIDTH-1 -: 2];

    // Data requested last cycle is on fifo_rd_data now and is always written.
    assign push = inflight;

    // Counting in-flight reads against free space guarantees that every
    // requested flit has a slot when it arrives, regardless of out_ready.
    assign fifo_rd_en = !rst && !fifo_empty &&
                        (({1'b0, occ} + {2'b00, inflight}) < 3'd3);

    assign accept = out_valid && out_ready;
    assign pop    = accept || orphan_pop;

    assign out_data = has_front ? front : '0;

    // Head and single types both have bit 0 set; those carry their own
    // destination, everything else belongs to the latched packet.
    assign out_dest = (has_front && front_type[0]) ? front[ADDR_WIDTH-1:0]
                                                    : dest_reg;

    // Framing decisions on the queue front: which flits are offered
    // downstream, which are discarded, and how the packet state moves.
    always_comb begin
        state_next = state;
        dest_next  = dest_reg;
        err_next   = 1'b0;
        count_inc  = 1'b0;
        orphan_pop = 1'b0;
        out_valid  = 1'b0;

        if (has_front) begin
            case (state)
                IDLE: begin
                    case (front_type)
                        TYPE_HEAD: begin
                            out_valid = 1'b1;
                            if (out_ready) begin
                                dest_next  = front[ADDR_WIDTH-1:0];
                                state_next = IN_PKT;
                            end
                        end
                        TYPE_SINGLE: begin
                            out_valid = 1'b1;
                            if (out_ready) begin
                                count_inc = 1'b1;
                            end
                        end
                        default: begin
                            // Body or tail with no open packet: drop it.
                            orphan_pop = 1'b1;
                            err_next   = 1'b1;
                        end
                    endcase
                end
                IN_PKT: begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        case (front_type)
                            TYPE_BODY: begin
                                state_next = IN_PKT;
                            end
                            TYPE_TAIL: begin
                                count_inc  = 1'b1;
                                state_next = IDLE;
                            end
                            TYPE_HEAD: begin
                                // Previous packet never closed; start over.
                                err_next   = 1'b1;
                                dest_next  = front[ADDR_WIDTH-1:0];
                                state_next = IN_PKT;
                            end
                            default: begin
                                err_next   = 1'b1;
                                count_inc  = 1'b1;
                                state_next = IDLE;
                            end
                        endcase
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Skid queue storage, pointers and occupancy. A simultaneous push and pop
    // advances both pointers and leaves occupancy alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                queue_mem[i] <= '0;
            end
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            occ      <= 2'd0;
            inflight <= 1'b0;
        end else begin
            if (push) begin
                queue_mem[wr_ptr] <= fifo_rd_data;
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
            inflight <= fifo_rd_en;
        end
    end

    // Framing state, latched destination, error pulse and packet counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dest_reg  <= '0;
            pkt_err   <= 1'b0;
            pkt_count <= 16'd0;
        end else begin
            state    <= state_next;
            dest_reg <= dest_next;
            pkt_err  <= err_next;
            if (count_inc) begin
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end

endmodule
